// File: rtl/soh_operand_decoder.sv
// ============================================================================
// soh_operand_decoder
//   Decodes PA-RISC instruction words into the SOH select and immediate, and
//   registers them across ID/EX through a 2-entry skid buffer.
//   Optional feature macro: SOH_ILLEGAL_TRAP_EN (drives illegal_op per entry).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module soh_operand_decoder #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [2:0]  soh_s,
    output logic [20:0] soh_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        illegal_op
);

    // Entry layout: {illegal, S[2:0], I[20:0]}
    function automatic logic [24:0] decode(input logic [31:0] w);
        logic [24:0] d;
        d = {1'b1, 3'b111, 21'd0};
        case (w[31:26])
            6'h02:               d = {1'b0, 3'b000, 21'd0};
            6'h2C, 6'h2D, 6'h25: d = {1'b0, 3'b001, 10'd0, w[10:0]};
            6'h0D, 6'h12, 6'h1A: d = {1'b0, 3'b010, 7'd0, w[13:0]};
            6'h08, 6'h0A:        d = {1'b0, 3'b011, w[20:0]};
            6'h34: begin
                if (w[12:10] == 3'b110)
                    d = {1'b0, 3'b100, 11'd0, w[9:0]};
                else if (w[12:10] == 3'b111)
                    d = {1'b0, 3'b101, 11'd0, w[9:0]};
            end
            6'h35:               d = {1'b0, 3'b110, 11'd0, w[9:0]};
            default:             d = {1'b1, 3'b111, 21'd0};
        endcase
        return d;
    endfunction

`ifdef SOH_ILLEGAL_TRAP_EN
    localparam logic c_trap_en = 1'b1;
`else
    localparam logic c_trap_en = 1'b0;
`endif

    // A reset word that does not decode leaves the entries as a cleared bubble.
    localparam logic [24:0] c_rst_dec    = decode(RESET_INSTR);
    localparam logic [24:0] c_rst_fields = c_rst_dec[24] ? 25'd0 : c_rst_dec;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [24:0] out_entry, skid_entry;
    logic [24:0] dec_raw, dec_in;
    logic        accept, drain;
    logic        load_out_new, load_out_skid, load_skid;

    assign dec_raw  = decode(instr);
    assign dec_in   = {dec_raw[24] & c_trap_en, dec_raw[23:0]};

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_out_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_nxt     = ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Data only moves on loads; invalidated entries keep their last contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_entry  <= c_rst_fields;
            skid_entry <= c_rst_fields;
        end else begin
            if (load_out_new)       out_entry <= dec_in;
            else if (load_out_skid) out_entry <= skid_entry;
            if (load_skid)          skid_entry <= dec_in;
        end
    end

    assign illegal_op = out_entry[24];
    assign soh_s      = out_entry[23:21];
    assign soh_i      = out_entry[20:0];

endmodule

`default_nettype wire
